// File: rtl/clock_pkg.sv
// Shared encodings for the 12-hour clock set controller.
// Mode codes and BCD field limits.
package clock_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h11;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Key, live-time and shadow-time bundle between
// the set controller and the counter chain / display.
interface clock_set_ctrl_if;

  logic       key_mode;
  logic       key_inc;
  logic [3:0] cur_sec_1;
  logic [3:0] cur_sec_2;
  logic [3:0] cur_min_1;
  logic [3:0] cur_min_2;
  logic [3:0] cur_hour_1;
  logic [3:0] cur_hour_2;
  logic       cnt_en;
  logic       load;
  logic [3:0] set_sec_1;
  logic [3:0] set_sec_2;
  logic [3:0] set_min_1;
  logic [3:0] set_min_2;
  logic [3:0] set_hour_1;
  logic [3:0] set_hour_2;
  logic [1:0] mode;
  logic       blink_on;

  modport master (
    output key_mode, key_inc,
    output cur_sec_1, cur_sec_2,
    output cur_min_1, cur_min_2,
    output cur_hour_1, cur_hour_2,
    input  cnt_en, load, mode, blink_on,
    input  set_sec_1, set_sec_2,
    input  set_min_1, set_min_2,
    input  set_hour_1, set_hour_2
  );

  modport slave (
    input  key_mode, key_inc,
    input  cur_sec_1, cur_sec_2,
    input  cur_min_1, cur_min_2,
    input  cur_hour_1, cur_hour_2,
    output cnt_en, load, mode, blink_on,
    output set_sec_1, set_sec_2,
    output set_min_1, set_min_2,
    output set_hour_1, set_hour_2
  );

endinterface

// File: rtl/bcd_field_inc.sv
// Two-digit BCD +1 with wrap to 00 past max_i.
// No carry out: fields are edited independently.
module bcd_field_inc (
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic [7:0] max_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // wrapped increment of one field
  always_comb begin
    tens_o = tens_i;
    ones_o = ones_i + 4'd1;
    if ({tens_i, ones_i} == max_i) begin
      tens_o = 4'd0;
      ones_o = 4'd0;
    end else if (ones_i >= 4'd9) begin
      tens_o = tens_i + 4'd1;
      ones_o = 4'd0;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode / time-set controller for the BCD clock:
// 1 Hz tick, shadow-time editing, commit load pulse.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_DIV   = 50_000_000,
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  clock_set_ctrl_if.slave   bus
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_HOUR   = 3'd1;
  localparam logic [2:0] ST_MIN    = 3'd2;
  localparam logic [2:0] ST_SEC    = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV) + 1;
  localparam int TW = $clog2(TIMEOUT_S) + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_S - 1);

  logic [2:0]    state_q, state_d;
  logic          mkey_q, ikey_q;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    hour_q, hour_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;

  logic       mode_edge, inc_edge;
  logic       in_set, wrap, timeout;
  logic [7:0] hour_nx, min_nx, sec_nx;

  assign mode_edge = bus.key_mode & ~mkey_q;
  assign inc_edge  = bus.key_inc & ~ikey_q;
  assign in_set    = (state_q == ST_HOUR) |
                     (state_q == ST_MIN) |
                     (state_q == ST_SEC);
  assign wrap      = (div_q == DIV_LAST);
  assign timeout   = in_set & wrap &
                     ~mode_edge & ~inc_edge &
                     (to_q == TO_LAST);

  bcd_field_inc u_hour_inc (
    .tens_i (hour_q[7:4]),
    .ones_i (hour_q[3:0]),
    .max_i  (HOUR_MAX),
    .tens_o (hour_nx[7:4]),
    .ones_o (hour_nx[3:0])
  );

  bcd_field_inc u_min_inc (
    .tens_i (min_q[7:4]),
    .ones_i (min_q[3:0]),
    .max_i  (MINSEC_MAX),
    .tens_o (min_nx[7:4]),
    .ones_o (min_nx[3:0])
  );

  bcd_field_inc u_sec_inc (
    .tens_i (sec_q[7:4]),
    .ones_i (sec_q[3:0]),
    .max_i  (MINSEC_MAX),
    .tens_o (sec_nx[7:4]),
    .ones_o (sec_nx[3:0])
  );

  // mode FSM and shadow-time editing
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    unique case (1'b1)
      (state_q == ST_RUN): begin
        if (mode_edge) begin
          state_d = ST_HOUR;
          hour_d  = {bus.cur_hour_2, bus.cur_hour_1};
          min_d   = {bus.cur_min_2, bus.cur_min_1};
          sec_d   = {bus.cur_sec_2, bus.cur_sec_1};
        end
      end
      (state_q == ST_HOUR): begin
        if (mode_edge)     state_d = ST_MIN;
        else if (inc_edge) hour_d  = hour_nx;
        else if (timeout)  state_d = ST_RUN;
      end
      (state_q == ST_MIN): begin
        if (mode_edge)     state_d = ST_SEC;
        else if (inc_edge) min_d   = min_nx;
        else if (timeout)  state_d = ST_RUN;
      end
      (state_q == ST_SEC): begin
        if (mode_edge)     state_d = ST_COMMIT;
        else if (inc_edge) sec_d   = sec_nx;
        else if (timeout)  state_d = ST_RUN;
      end
      (state_q == ST_COMMIT): state_d = ST_RUN;
      default:                state_d = ST_RUN;
    endcase
  end

  // tick divider, blink phase and idle timeout
  always_comb begin
    div_d   = div_q + DW'(1);
    blk_d   = blk_q;
    blink_d = blink_q;
    to_d    = to_q;
    if (state_q == ST_COMMIT || wrap) div_d = '0;
    if (!in_set) begin
      blk_d   = '0;
      blink_d = 1'b1;
    end else if (blk_q == BLK_LAST) begin
      blk_d   = '0;
      blink_d = ~blink_q;
    end else begin
      blk_d   = blk_q + BW'(1);
    end
    if (!in_set || mode_edge || inc_edge) to_d = '0;
    else if (wrap) to_d = timeout ? '0 : to_q + TW'(1);
  end

  // state registers, key history resets high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      mkey_q  <= 1'b1;
      ikey_q  <= 1'b1;
      div_q   <= '0;
      blk_q   <= '0;
      blink_q <= 1'b1;
      to_q    <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      mkey_q  <= bus.key_mode;
      ikey_q  <= bus.key_inc;
      div_q   <= div_d;
      blk_q   <= blk_d;
      blink_q <= blink_d;
      to_q    <= to_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  // mode code seen by the display; COMMIT reads as RUN
  always_comb begin
    bus.mode = MODE_RUN;
    unique case (1'b1)
      (state_q == ST_HOUR): bus.mode = MODE_SET_HOUR;
      (state_q == ST_MIN):  bus.mode = MODE_SET_MIN;
      (state_q == ST_SEC):  bus.mode = MODE_SET_SEC;
      default:              bus.mode = MODE_RUN;
    endcase
  end

  assign bus.cnt_en     = (state_q == ST_RUN) & wrap;
  assign bus.load       = (state_q == ST_COMMIT);
  assign bus.blink_on   = blink_q;
  assign bus.set_hour_1 = hour_q[3:0];
  assign bus.set_hour_2 = hour_q[7:4];
  assign bus.set_min_1  = min_q[3:0];
  assign bus.set_min_2  = min_q[7:4];
  assign bus.set_sec_1  = sec_q[3:0];
  assign bus.set_sec_2  = sec_q[7:4];

endmodule
